// File: rtl/mul_arbiter_ctrl.sv
// Round-robin controller sharing one iterative radix-16 Booth multiplier core
// between the integer pipe (port 0) and the FPU mantissa path (port 1).
module mul_arbiter_ctrl #(
  parameter int WIDTH     = 52,
  parameter int MULCYCLES = (WIDTH + 3) / 4,
  parameter int CNT_W     = $clog2(MULCYCLES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [WIDTH-1:0]     req0_a_i,
  input  logic [WIDTH-1:0]     req0_b_i,
  input  logic                 req0_signed_i,
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [WIDTH-1:0]     req1_a_i,
  input  logic [WIDTH-1:0]     req1_b_i,
  input  logic                 req1_signed_i,
  output logic                 core_load_o,
  output logic                 core_en_o,
  output logic [CNT_W-1:0]     core_iter_o,
  output logic [WIDTH-1:0]     core_a_o,
  output logic [WIDTH-1:0]     core_b_o,
  output logic                 core_signed_o,
  input  logic [2*WIDTH-1:0]   core_product_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [2*WIDTH-1:0]   res_product_o,
  output logic                 res_tag_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, ITER, CAPT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULCYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             last_grant;
  logic             grant;

  // On a tie the port that did not win last time gets the core.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  always_comb grant = pick_grant(req0_valid_i, req1_valid_i, last_grant);

  assign req0_ready_o = (state == IDLE) && req0_valid_i && !grant;
  assign req1_ready_o = (state == IDLE) && req1_valid_i &&  grant;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      counter       <= '0;
      last_grant    <= 1'b1;
      core_a_o      <= '0;
      core_b_o      <= '0;
      core_signed_o <= 1'b0;
      core_load_o   <= 1'b0;
      core_en_o     <= 1'b0;
      core_iter_o   <= '0;
      res_product_o <= '0;
      res_tag_o     <= 1'b0;
      res_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready_o || req1_ready_o) begin
            core_a_o      <= grant ? req1_a_i : req0_a_i;
            core_b_o      <= grant ? req1_b_i : req0_b_i;
            core_signed_o <= grant ? req1_signed_i : req0_signed_i;
            res_tag_o     <= grant;
            last_grant    <= grant;
            counter       <= '0;
            core_load_o   <= 1'b1;
            core_en_o     <= 1'b1;
            core_iter_o   <= '0;
            busy_o        <= 1'b1;
            state         <= ITER;
          end
        end
        // One radix-16 digit per cycle; load is only asserted on digit 0.
        ITER: begin
          core_load_o <= 1'b0;
          if (counter == LAST_ITER) begin
            counter     <= '0;
            core_en_o   <= 1'b0;
            core_iter_o <= '0;
            state       <= CAPT;
          end else begin
            counter     <= counter + 1'b1;
            core_iter_o <= counter + 1'b1;
          end
        end
        CAPT: begin
          res_product_o <= core_product_i;
          res_valid_o   <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter_ctrl.sv
// Bench for mul_arbiter_ctrl: a behavioural core stand-in plus a timeline
// model of the controller compared against the DUT on every falling edge.
module tb_mul_arbiter_ctrl;
  localparam int WIDTH     = 52;
  localparam int MULCYCLES = 13;
  localparam int CNT_W     = 4;
  localparam int PW        = 2 * WIDTH;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic              req0_ready_o, req1_ready_o;
  logic [WIDTH-1:0]  req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
  logic              req0_signed_i = 1'b0, req1_signed_i = 1'b0;
  logic              core_load_o, core_en_o, core_signed_o;
  logic [CNT_W-1:0]  core_iter_o;
  logic [WIDTH-1:0]  core_a_o, core_b_o;
  logic [PW-1:0]     core_product_i = '0;
  logic              res_valid_o, res_tag_o, busy_o;
  logic              res_ready_i = 1'b1;
  logic [PW-1:0]     res_product_o;

  int n_chk = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  mul_arbiter_ctrl #(.WIDTH(WIDTH), .MULCYCLES(MULCYCLES), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_a_i(req0_a_i),
    .req0_b_i(req0_b_i), .req0_signed_i(req0_signed_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_a_i(req1_a_i),
    .req1_b_i(req1_b_i), .req1_signed_i(req1_signed_i),
    .core_load_o(core_load_o), .core_en_o(core_en_o), .core_iter_o(core_iter_o),
    .core_a_o(core_a_o), .core_b_o(core_b_o), .core_signed_o(core_signed_o),
    .core_product_i(core_product_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_product_o(res_product_o),
    .res_tag_o(res_tag_o), .busy_o(busy_o)
  );

  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic s);
    logic signed [PW-1:0] sa, sb;
    if (s) begin
      sa = {{WIDTH{a[WIDTH-1]}}, a};
      sb = {{WIDTH{b[WIDTH-1]}}, b};
      return $unsigned(sa * sb);
    end
    return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  endfunction

  function automatic logic [WIDTH-1:0] rnd();
    return WIDTH'({$urandom(), $urandom()});
  endfunction

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Core stand-in: the product appears only in the cycle after 13 in-order digits.
  int               k_cnt = 0;
  logic [WIDTH-1:0] ca = '0, cb = '0;
  logic             cs = 1'b0;
  always @(posedge clk) begin
    logic hit;
    hit = 1'b0;
    if (core_en_o) begin
      if (core_load_o && core_iter_o == 0) begin
        ca = core_a_o; cb = core_b_o; cs = core_signed_o; k_cnt = 1;
      end else if (!core_load_o && core_iter_o == CNT_W'(k_cnt)) k_cnt++;
      else k_cnt = -100;
      if (k_cnt == MULCYCLES) begin hit = 1'b1; k_cnt = 0; end
    end else k_cnt = 0;
    #1;
    core_product_i = hit ? ref_mul(ca, cb, cs) : ({PW{1'b1}} ^ {ca, cb});
  end

  // Timeline model: m_age counts cycles since the accepting edge.
  logic             m_busy = 1'b0, m_resv = 1'b0, m_last = 1'b1, m_tag = 1'b0, m_s = 1'b0;
  int               m_age = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic [PW-1:0]    m_prod = '0;

  function automatic logic exp_rdy(input int n);
    logic g;
    g = (req0_valid_i && req1_valid_i) ? !m_last : req1_valid_i;
    if (m_busy) return 1'b0;
    return (n == 0) ? (req0_valid_i && !g) : (req1_valid_i && g);
  endfunction

  always @(posedge clk) begin
    logic r0, r1;
    r0 = exp_rdy(0);
    r1 = exp_rdy(1);
    if (!rst_ni) begin
      m_busy = 1'b0; m_resv = 1'b0; m_age = 0; m_last = 1'b1;
    end else if (!m_busy) begin
      if (r0 || r1) begin
        m_a = r1 ? req1_a_i : req0_a_i;
        m_b = r1 ? req1_b_i : req0_b_i;
        m_s = r1 ? req1_signed_i : req0_signed_i;
        m_tag = r1; m_last = r1; m_busy = 1'b1; m_age = 1;
      end
    end else if (m_resv) begin
      if (res_ready_i) begin m_resv = 1'b0; m_busy = 1'b0; m_age = 0; end
    end else begin
      m_age++;
      if (m_age == MULCYCLES + 2) begin m_resv = 1'b1; m_prod = ref_mul(m_a, m_b, m_s); end
    end
  end

  always @(negedge clk) begin
    logic en_e;
    if (chk_on) begin
      en_e = m_busy && m_age >= 1 && m_age <= MULCYCLES;
      chk("busy", PW'(busy_o), PW'(m_busy));
      chk("core_load", PW'(core_load_o), PW'(m_busy && m_age == 1));
      chk("core_en", PW'(core_en_o), PW'(en_e));
      chk("core_iter", PW'(core_iter_o), en_e ? PW'(m_age - 1) : '0);
      chk("res_valid", PW'(res_valid_o), PW'(m_resv));
      chk("req0_ready", PW'(req0_ready_o), PW'(exp_rdy(0)));
      chk("req1_ready", PW'(req1_ready_o), PW'(exp_rdy(1)));
      if (en_e) begin
        chk("core_a", PW'(core_a_o), PW'(m_a));
        chk("core_b", PW'(core_b_o), PW'(m_b));
        chk("core_signed", PW'(core_signed_o), PW'(m_s));
      end
      if (m_resv) begin
        chk("res_product", res_product_o, m_prod);
        chk("res_tag", PW'(res_tag_o), PW'(m_tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_zero(input string nm);
    chk({nm, "_core_a"}, PW'(core_a_o), '0);
    chk({nm, "_core_b"}, PW'(core_b_o), '0);
    chk({nm, "_core_signed"}, PW'(core_signed_o), '0);
    chk({nm, "_res_product"}, res_product_o, '0);
    chk({nm, "_res_tag"}, PW'(res_tag_o), '0);
    chk({nm, "_res_valid"}, PW'(res_valid_o), '0);
    chk({nm, "_core_load"}, PW'(core_load_o), '0);
    chk({nm, "_core_en"}, PW'(core_en_o), '0);
    chk({nm, "_core_iter"}, PW'(core_iter_o), '0);
    chk({nm, "_busy"}, PW'(busy_o), '0);
  endtask

  task automatic issue(input int port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s);
    int n;
    if (port == 0) begin req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; req0_signed_i = s; end
    else begin req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; req1_signed_i = s; end
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (port == 0 ? req0_ready_o : req1_ready_o) break;
      n++;
    end
    if (n >= 100) begin
      n_chk++; n_err++;
      $display("FAIL issue_timeout: port %0d never ready", port);
    end
    tick();
    if (port == 0) begin req0_valid_i = 1'b0; req0_a_i = rnd(); req0_b_i = rnd(); end
    else begin req1_valid_i = 1'b0; req1_a_i = rnd(); req1_b_i = rnd(); end
  endtask

  task automatic wait_result(input logic [PW-1:0] ep, input logic et, input string nm);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (res_valid_o) break;
      n++;
    end
    if (n >= 200) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: res_valid never rose", nm);
    end else begin
      chk({nm, "_product"}, res_product_o, ep);
      chk({nm, "_tag"}, PW'(res_tag_o), PW'(et));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    logic [PW-1:0]    e0, e1;
    logic             s;
    int               n;

    repeat (3) tick();
    chk_on = 1'b1;
    @(negedge clk);
    check_reset_zero("reset");
    tick();
    rst_ni = 1'b1;

    // single unsigned request on port 0
    issue(0, 52'h3, 52'h5, 1'b0);
    wait_result(104'hF, 1'b0, "single");
    tick();

    // signed request on port 1: -7 * 6
    issue(1, ~52'd6, 52'd6, 1'b1);
    wait_result(~104'd41, 1'b1, "signed");
    tick();

    // both ports held from reset: grants alternate 0,1,0,1
    rst_ni = 1'b0;
    req0_valid_i = 1'b1; req0_a_i = 52'd2; req0_b_i = 52'd3; req0_signed_i = 1'b0;
    req1_valid_i = 1'b1; req1_a_i = 52'd4; req1_b_i = 52'd5; req1_signed_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_result((i % 2) ? 104'd20 : 104'd6, (i % 2) != 0, "arb");
      tick();
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();

    // backpressure: result held 20 cycles while port 1 waits
    res_ready_i = 1'b0;
    a = rnd(); b = rnd(); s = 1'($urandom_range(0, 1));
    e0 = ref_mul(a, b, s);
    issue(0, a, b, s);
    req1_a_i = rnd(); req1_b_i = rnd(); req1_signed_i = 1'b1;
    e1 = ref_mul(req1_a_i, req1_b_i, 1'b1);
    req1_valid_i = 1'b1;
    wait_result(e0, 1'b0, "bp");
    repeat (20) begin
      @(negedge clk);
      chk("bp_hold_product", res_product_o, e0);
      chk("bp_hold_valid", PW'(res_valid_o), PW'(1'b1));
    end
    tick();
    res_ready_i = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (req1_ready_o) break;
      n++;
    end
    chk("bp_ready_delay", PW'(n), PW'(1));
    tick();
    req1_valid_i = 1'b0;
    wait_result(e1, 1'b1, "bp_next");
    tick();

    // reset while the core is on digit 6
    issue(1, rnd(), rnd(), 1'b0);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (core_en_o && core_iter_o == 4'd6) break;
      n++;
    end
    chk("midreset_reach_iter6", PW'(n < 50), PW'(1'b1));
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    check_reset_zero("midreset");
    repeat (20) tick();

    // largest unsigned operands
    issue(0, {WIDTH{1'b1}}, {WIDTH{1'b1}}, 1'b0);
    wait_result({52'hFFFFFFFFFFFFE, 52'h0000000000001}, 1'b0, "max");
    tick();

    // random traffic with random backpressure
    for (int c = 0; c < 2000; c++) begin
      req0_valid_i = $urandom_range(0, 3) != 0;
      req1_valid_i = $urandom_range(0, 3) != 0;
      req0_a_i = rnd(); req0_b_i = rnd(); req0_signed_i = 1'($urandom_range(0, 1));
      req1_a_i = rnd(); req1_b_i = rnd(); req1_signed_i = 1'($urandom_range(0, 1));
      res_ready_i = $urandom_range(0, 3) != 0;
      tick();
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; res_ready_i = 1'b1;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_arbiter_ctrl.md
Name: mul_arbiter_ctrl

Overview:
- Controller/arbiter that shares one iterative radix-16 Booth multiplier core between two requesters: port 0 (integer pipe) and port 1 (FPU mantissa path).
- Accepts one operation per port via valid/ready and arbitrates round-robin.
- Sequences the core through MULCYCLES iterations, captures the product and returns it with a requester tag over a valid/ready result channel with backpressure.

Parameters:
- WIDTH, 52, operand width in bits.
- MULCYCLES, ceil(WIDTH/4) = 13, core iterations per multiplication (one radix-16 digit per cycle).
- CNT_W, clog2(MULCYCLES) = 4, iteration counter width.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- req0_valid_i  in  1  port 0 request valid.
- req0_ready_o  out  1  port 0 request accepted this cycle.
- req0_a_i  in  WIDTH  port 0 multiplicand.
- req0_b_i  in  WIDTH  port 0 multiplier.
- req0_signed_i  in  1  port 0 two's-complement operands.
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_signed_i  same as port 0, for port 1.
- core_load_o  out  1  core clears accumulator and loads operands.
- core_en_o  out  1  core performs one iteration.
- core_iter_o  out  CNT_W  current digit index 0..MULCYCLES-1.
- core_a_o  out  WIDTH  registered multiplicand to core.
- core_b_o  out  WIDTH  registered multiplier to core.
- core_signed_o  out  1  registered signed flag to core.
- core_product_i  in  2*WIDTH  core accumulator, valid the cycle after the last iteration.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts result.
- res_product_o  out  2*WIDTH  registered product.
- res_tag_o  out  1  requester that issued the operation (0 or 1).
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_ni low at a clock edge):
  - state=IDLE, counter=0, last_grant=1 (so port 0 wins the first tie).
  - All registered outputs 0: core_a_o, core_b_o, core_signed_o, res_product_o, res_tag_o, res_valid_o, core_load_o, core_en_o, core_iter_o, busy_o.
  - Reset mid-operation aborts immediately. No result is produced and the core is not driven until the next grant.
- States: IDLE, ITER, CAPT, DONE.
- IDLE:
  - grant = port 1 if only req1 is valid; port 0 if only req0 is valid; if both are valid, the port not equal to last_grant.
  - reqN_ready_o = (state==IDLE) && reqN_valid_i && grant==N. This is combinational and at most one ready is high per cycle.
  - On handshake: latch operands, signed flag and tag (=grant); last_grant<=grant; counter<=0; go to ITER.
  - With no valid request, stay in IDLE.
- ITER:
  - core_en_o=1, core_iter_o=counter.
  - core_load_o=1 only when counter==0.
  - counter increments each cycle. When counter==MULCYCLES-1, go to CAPT.
  - Exactly MULCYCLES cycles in ITER.
- CAPT:
  - One cycle, core_en_o=0.
  - res_product_o<=core_product_i, res_valid_o<=1. Go to DONE.
- DONE:
  - res_valid_o held high. Product and tag are stable until res_valid_o && res_ready_i.
  - On accept: res_valid_o<=0, go to IDLE.
  - No new grant in the accept cycle. Request ready lines stay 0 in ITER, CAPT and DONE.
- Latency:
  - Request handshake at edge T gives core_load_o at cycle T+1 and res_valid_o at cycle T+MULCYCLES+2 (15 at default).
  - Minimum spacing between grants is MULCYCLES+3 cycles when res_ready_i is tied high.
- Boundaries:
  - A request dropped before its ready has no effect.
  - A losing requester keeps valid and wins at the next IDLE.
  - A held res_ready_i=0 stalls indefinitely without corrupting the result.
  - Operand inputs are ignored outside the handshake cycle.
  - Product width is exactly 2*WIDTH with no truncation.

Test Plan:
- Single request: req0 a=0x3, b=0x5, unsigned, res_ready=1 -> core_load_o at T+1, 13 core_en_o pulses with iter 0..12, res_valid at T+15, product=0xF, tag=0.
- Signed: req1 a=-7 (52-bit two's complement), b=6, signed=1 -> product=-42 sign-extended to 104 bits, tag=1.
- Arbitration: both valid from reset with ops (2x3 on port 0, 4x5 on port 1), both held -> grant 0 first (product 6, tag 0), then grant 1 (product 20, tag 1); two more back-to-back pairs alternate 0,1,0,1.
- Backpressure: res_ready=0 for 20 cycles after res_valid -> res_valid, product and tag stable and no new ready; res_ready=1 -> accepted, req ready appears the cycle after.
- Reset mid-op: rst_ni low at iter 6 for one edge -> all outputs 0, state IDLE, no res_valid; the next request completes normally.
- Max operands: a=b=2^52-1 unsigned -> product=2^104-2^53+1.
